// File: rtl/dice_pkg.sv
// Shared definitions for the dice roller.
//   - die_e        : die encoding carried on roll_die (D4..D20, NONE = 7)
//   - faceCount()  : die -> number of faces N
//   - segDigit()   : decimal digit -> active-low {g,f,e,d,c,b,a} pattern
//   - LFSR_W/TAPS  : width and feedback taps of the face LFSR
package dice_pkg;

    localparam int NUM_DICE = 6;

    typedef enum logic [2:0] {
        DIE_D4   = 3'd0,
        DIE_D6   = 3'd1,
        DIE_D8   = 3'd2,
        DIE_D10  = 3'd3,
        DIE_D12  = 3'd4,
        DIE_D20  = 3'd5,
        DIE_NONE = 3'd7
    } die_e;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form:
    // the feedback bit is the XOR of state bits 0, 2, 3 and 5.
    localparam int               LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [4:0] faceCount(input die_e d);
        case (d)
            DIE_D4:  return 5'd4;
            DIE_D6:  return 5'd6;
            DIE_D8:  return 5'd8;
            DIE_D10: return 5'd10;
            DIE_D12: return 5'd12;
            DIE_D20: return 5'd20;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [6:0] segDigit(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/dice_debounce.sv
// One button input path: 2-FF synchronizer followed by a debouncer.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   button : raw asynchronous button level
//   level  : debounced level; follows the synchronized input only after it
//            has differed from the current level for DEBOUNCE_CYCLES cycles
module dice_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            count <= '0;
            level <= 1'b0;
        end else begin
            sync0 <= button;
            sync1 <= sync0;
            // Agreement with the current level (a bounce back) restarts the window.
            if (sync1 == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                level <= sync1;
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dice_top.sv
// Dice roller top level.
//   clk                 : system clock
//   reset_n             : asynchronous reset, asserted when HIGH (legacy name)
//   buttonD4..buttonD20 : raw active-high die-select buttons
//   switchTest          : 1 = result is the die's maximum face
//   roll_value          : last rolled face 1..20 (0 after reset)
//   roll_die            : last die encoding (7 = none)
//   roll_valid          : one-cycle pulse when roll_value/roll_die update
//   seg_tens, seg_ones  : active-low seven-segment digits, lag roll_value by 1
module dice_top
    import dice_pkg::*;
#(
    parameter int                DEBOUNCE_CYCLES = 1000,
    parameter logic [LFSR_W-1:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       buttonD4,
    input  logic       buttonD6,
    input  logic       buttonD8,
    input  logic       buttonD10,
    input  logic       buttonD12,
    input  logic       buttonD20,
    input  logic       switchTest,
    output logic [4:0] roll_value,
    output logic [2:0] roll_die,
    output logic       roll_valid,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
);

    logic rst;
    assign rst = reset_n;

    function automatic logic [4:0] rollFace(input die_e d, input logic [LFSR_W-1:0] r,
                                            input logic testMode);
        if (testMode) return faceCount(d);
        case (d)
            DIE_D4:  return 5'(r % 16'd4)  + 5'd1;
            DIE_D6:  return 5'(r % 16'd6)  + 5'd1;
            DIE_D8:  return 5'(r % 16'd8)  + 5'd1;
            DIE_D10: return 5'(r % 16'd10) + 5'd1;
            DIE_D12: return 5'(r % 16'd12) + 5'd1;
            DIE_D20: return 5'(r % 16'd20) + 5'd1;
            default: return 5'd0;
        endcase
    endfunction

    logic [NUM_DICE-1:0] rawButtons;
    logic [NUM_DICE-1:0] levels;
    logic [NUM_DICE-1:0] levelsPrev;
    logic [NUM_DICE-1:0] events_p0;

    logic [LFSR_W-1:0] lfsr;
    logic              lfsrFb;

    logic       hit_p0;
    die_e       rollDie_p0;
    logic [4:0] rollValue_p0;

    logic [4:0] rollValue_p1;
    die_e       rollDie_p1;
    logic       vld_p1;
    logic [1:0] tens_p1;
    logic [3:0] ones_p1;
    logic [6:0] segTensNext;
    logic [6:0] segOnesNext;

    logic [6:0] segTens_p2;
    logic [6:0] segOnes_p2;

    assign rawButtons = {buttonD20, buttonD12, buttonD10, buttonD8, buttonD6, buttonD4};

    for (genvar i = 0; i < NUM_DICE; i++) begin : gDebounce
        dice_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uDebounce (
            .clk   (clk),
            .rst   (rst),
            .button(rawButtons[i]),
            .level (levels[i])
        );
    end

    // ---- stage p0: press events, priority select, face ----
    assign events_p0 = levels & ~levelsPrev;
    assign lfsrFb    = ^(lfsr & LFSR_TAPS);

    always_comb begin
        hit_p0     = 1'b0;
        rollDie_p0 = DIE_NONE;
        // Descending scan so the lowest index (smallest die) is the final winner.
        for (int i = NUM_DICE - 1; i >= 0; i--) begin
            if (events_p0[i]) begin
                hit_p0     = 1'b1;
                rollDie_p0 = die_e'(3'(i));
            end
        end
        rollValue_p0 = rollFace(rollDie_p0, lfsr, switchTest);
    end

    // ---- stage p1: latched roll result, digit split ----
    always_comb begin
        tens_p1 = 2'd0;
        ones_p1 = 4'(rollValue_p1);
        if (rollValue_p1 >= 5'd20) begin
            tens_p1 = 2'd2;
            ones_p1 = 4'(rollValue_p1 - 5'd20);
        end else if (rollValue_p1 >= 5'd10) begin
            tens_p1 = 2'd1;
            ones_p1 = 4'(rollValue_p1 - 5'd10);
        end
        segTensNext = SEG_BLANK;
        segOnesNext = SEG_BLANK;
        if (rollDie_p1 != DIE_NONE) begin
            segOnesNext = segDigit(ones_p1);
            if (tens_p1 != 2'd0) segTensNext = segDigit({2'b00, tens_p1});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            levelsPrev   <= '0;
            vld_p1       <= 1'b0;
            rollValue_p1 <= 5'd0;
            rollDie_p1   <= DIE_NONE;
            segTens_p2   <= SEG_BLANK;
            segOnes_p2   <= SEG_BLANK;
        end else begin
            lfsr       <= {lfsrFb, lfsr[LFSR_W-1:1]};
            levelsPrev <= levels;
            vld_p1     <= hit_p0;
            if (hit_p0) begin
                rollValue_p1 <= rollValue_p0;
                rollDie_p1   <= rollDie_p0;
            end
            // ---- stage p2: segment patterns ----
            segTens_p2 <= segTensNext;
            segOnes_p2 <= segOnesNext;
        end
    end

    assign roll_value = rollValue_p1;
    assign roll_die   = rollDie_p1;
    assign roll_valid = vld_p1;
    assign seg_tens   = segTens_p2;
    assign seg_ones   = segOnes_p2;

endmodule

// File: tb/tb_dice_top.sv
// Self-checking bench for dice_top: table of test-mode presses plus
// hand-written bounce, simultaneous, reset and normal-mode sequences.
module tb_dice_top;

    localparam int DB   = 4;
    localparam int LAT  = 3 + DB;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] btn;
    logic       switchTest;
    logic [4:0] roll_value;
    logic [2:0] roll_die;
    logic       roll_valid;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    int passCnt  = 0;
    int totalCnt = 0;

    dice_top #(
        .DEBOUNCE_CYCLES(DB),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .buttonD4  (btn[0]),
        .buttonD6  (btn[1]),
        .buttonD8  (btn[2]),
        .buttonD10 (btn[3]),
        .buttonD12 (btn[4]),
        .buttonD20 (btn[5]),
        .switchTest(switchTest),
        .roll_value(roll_value),
        .roll_die  (roll_die),
        .roll_valid(roll_valid),
        .seg_tens  (seg_tens),
        .seg_ones  (seg_ones)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Fibonacci x^16+x^14+x^13+x^11+1, shifting right.
    logic [15:0] mCur;
    logic [15:0] mPrev;
    always @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            mCur  <= SEED;
            mPrev <= SEED;
        end else begin
            mPrev <= mCur;
            mCur  <= {mCur[0] ^ mCur[2] ^ mCur[3] ^ mCur[5], mCur[15:1]};
        end
    end

    typedef struct {
        int         btnIdx;
        int         expValue;
        int         expDie;
        logic [6:0] expTens;
        logic [6:0] expOnes;
    } vec_t;

    vec_t vecs[6];
    int   faceN[6];
    bit   seen[6][21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idleCount(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (roll_valid) pulses++;
        end
    endtask

    task automatic waitRoll(input int maxTicks, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxTicks && !got; i++) begin
            tick();
            if (roll_valid) got = 1'b1;
        end
    endtask

    task automatic releaseAll();
        int p;
        btn = '0;
        idleCount(DB + 6, p);
        check("releaseNoRoll", p, 0);
    endtask

    initial begin
        int  p;
        bit  got;
        int  d;
        int  prevD;
        int  expF;

        vecs[0] = '{0, 4,  0, 7'h7F, 7'h19};
        vecs[1] = '{1, 6,  1, 7'h7F, 7'h02};
        vecs[2] = '{2, 8,  2, 7'h7F, 7'h00};
        vecs[3] = '{3, 10, 3, 7'h79, 7'h40};
        vecs[4] = '{4, 12, 4, 7'h79, 7'h24};
        vecs[5] = '{5, 20, 5, 7'h24, 7'h40};
        faceN   = '{4, 6, 8, 10, 12, 20};

        reset_n    = 1'b1;
        btn        = '0;
        switchTest = 1'b0;
        repeat (3) tick();
        check("rstValue", roll_value, 0);
        check("rstDie", roll_die, 7);
        check("rstValid", roll_valid, 0);
        check("rstSegTens", seg_tens, 7'h7F);
        check("rstSegOnes", seg_ones, 7'h7F);
        reset_n = 1'b0;
        #1;
        check("lfsrSeed", dut.lfsr, SEED);
        idleCount(5, p);
        check("idleNoRoll", p, 0);
        check("idleDie", roll_die, 7);
        check("idleSegOnes", seg_ones, 7'h7F);

        // Test-mode table: exact latency, values, segments, single pulse.
        switchTest = 1'b1;
        for (int v = 0; v < 6; v++) begin
            btn[vecs[v].btnIdx] = 1'b1;
            idleCount(LAT - 1, p);
            check("earlyPulse", p, 0);
            tick();
            check("pulseAtLatency", roll_valid, 1);
            check("tableValue", roll_value, vecs[v].expValue);
            check("tableDie", roll_die, vecs[v].expDie);
            tick();
            check("pulseWidth", roll_valid, 0);
            check("tableSegTens", seg_tens, vecs[v].expTens);
            check("tableSegOnes", seg_ones, vecs[v].expOnes);
            idleCount(20, p);
            check("holdNoRepeat", p, 0);
            releaseAll();
        end

        // Latched result is unaffected by later switchTest changes.
        switchTest = 1'b0;
        repeat (3) tick();
        check("latchedAfterSwitch", roll_value, 20);
        check("latchedSegTens", seg_tens, 7'h24);
        switchTest = 1'b1;

        // Bounce on D8: toggles every DB/2 cycles, then a steady hold.
        p = 0;
        for (int t = 0; t < 10; t++) begin
            int q;
            btn[2] = ~btn[2];
            idleCount(DB / 2, q);
            p += q;
        end
        check("bounceNoRoll", p, 0);
        btn[2] = 1'b1;
        idleCount(LAT - 1, p);
        check("bounceEarly", p, 0);
        tick();
        check("bouncePulse", roll_valid, 1);
        check("bounceValue", roll_value, 8);
        idleCount(10, p);
        check("bounceSingle", p, 0);
        releaseAll();

        // Simultaneous D10 and D4: smallest die wins, one pulse only.
        btn[3] = 1'b1;
        btn[0] = 1'b1;
        waitRoll(LAT + 4, got);
        check("simulGot", got, 1);
        check("simulDie", roll_die, 0);
        check("simulValue", roll_value, 4);
        idleCount(15, p);
        check("simulSingle", p, 0);
        releaseAll();

        // Reset mid-operation with D12 held.
        btn[4] = 1'b1;
        waitRoll(LAT + 4, got);
        check("preRstValue", roll_value, 12);
        reset_n = 1'b1;
        #1;
        check("asyncRstValue", roll_value, 0);
        check("asyncRstDie", roll_die, 7);
        check("asyncRstSegTens", seg_tens, 7'h7F);
        check("asyncRstSegOnes", seg_ones, 7'h7F);
        repeat (2) tick();
        reset_n = 1'b0;
        idleCount(LAT - 1, p);
        check("postRstEarly", p, 0);
        tick();
        check("postRstPulse", roll_valid, 1);
        check("postRstValue", roll_value, 12);
        check("postRstDie", roll_die, 4);
        releaseAll();

        // Normal mode: round-robin presses, each checked against the model.
        switchTest = 1'b0;
        prevD = -1;
        for (int k = 0; k < 6000; k++) begin
            d = k % 6;
            if (prevD >= 0) btn[prevD] = 1'b0;
            btn[d] = 1'b1;
            waitRoll(LAT + 4, got);
            check("normalGot", got, 1);
            if (got) begin
                expF = int'(mPrev % 16'(faceN[d])) + 1;
                check("normalModel", roll_value, expF);
                check("normalDie", roll_die, d);
                check("normalRange", (roll_value >= 1 && roll_value <= faceN[d]) ? 1 : 0, 1);
                if (roll_value <= 20) seen[d][roll_value] = 1'b1;
            end
            prevD = d;
            repeat ($urandom_range(0, 2)) tick();
        end
        releaseAll();
        for (int i = 0; i < 6; i++) begin
            int cnt;
            cnt = 0;
            for (int f = 1; f <= faceN[i]; f++) if (seen[i][f]) cnt++;
            check("faceCoverage", cnt, faceN[i]);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/dice_top.md
# dice_top

Top-level of the dice roller. Six active-high push buttons select a die (D4, D6, D8, D10, D12, D20). Each debounced press latches a pseudo-random face value 1..N and shows it on two active-low seven-segment digits. A test switch replaces the random value with the die's maximum face, giving deterministic verification.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required before a button level is accepted.
- LFSR_SEED, default 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-high. The port keeps the codebase name reset_n, but reset is asserted when reset_n is 1.
- buttonD4, buttonD6, buttonD8, buttonD10, buttonD12, buttonD20  in  1 each  raw, asynchronous, active-high buttons.
- switchTest  in  1  level; 1 selects test mode (result = max face).
- roll_value  out  5  last rolled face, 1..20; 0 after reset.
- roll_die  out  3  encoding of last die: 0=D4, 1=D6, 2=D8, 3=D10, 4=D12, 5=D20, 7=none (reset value).
- roll_valid  out  1  one-cycle pulse when roll_value/roll_die update.
- seg_tens, seg_ones  out  7 each  active-low segments {g,f,e,d,c,b,a}; reset value 7'h7F (blank).

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- A press event is a 0→1 transition of the debounced level.
  - Holding a button gives exactly one roll.
  - Release gives no roll.
- Simultaneous press events in the same cycle: the smallest die wins (D4 > D6 > D8 > D10 > D12 > D20). Other events in that cycle are discarded.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle regardless of buttons or mode.
  - Reset loads LFSR_SEED; the all-zero state is unreachable.
- Face computation:
  - Normal mode: face = (lfsr mod N) + 1, using the LFSR value present in the cycle of the press event.
  - Test mode: face = N.
  - N is the selected die's face count (4, 6, 8, 10, 12, 20).
- Display:
  - roll_value is converted to tens (0..2) and ones (0..9) digits.
  - seg_ones shows the ones digit.
  - seg_tens shows the tens digit, or blank (7'h7F) when tens = 0.
  - Both digits are blank while roll_die = 7.
- Digit patterns, active low, {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).

## Timing
- Button edge to debounced edge: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Press event to outputs:
  - roll_value, roll_die and roll_valid are registered and visible 1 cycle after the event cycle.
  - seg outputs are registered from roll_value and lag it by 1 cycle.
- roll_valid is high for exactly 1 cycle per accepted press.
- switchTest is sampled in the event cycle only. Changing it does not alter an already-latched result.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - Debounced levels clear to 0 and counters clear.
  - A button still held after reset releases produces one roll once it has been debounced.

## Structure
- Package dice_pkg holds:
  - die encoding constants (D4..D20, NONE=7);
  - face-count lookup (die → N);
  - seven-segment digit constants;
  - LFSR width and tap constants.
- Sub-module dice_debounce holds the synchronizer, counter and debounced level, parameterized by DEBOUNCE_CYCLES. dice_top instantiates it six times.
- LFSR, priority select, modulo and BCD/segment logic live in dice_top.

## Test plan
- Reset, then idle: roll_value=0, roll_die=7, roll_valid=0, both segments 7F. LFSR equals 16'hACE1 in the first cycle after reset release.
- switchTest=1, hold buttonD6:
  - after 2+DEBOUNCE_CYCLES+1 cycles, one roll_valid pulse with roll_value=6, roll_die=1;
  - next cycle seg_ones=02, seg_tens=7F;
  - no further pulses while the button is held.
- switchTest=1, press D20: roll_value=20, seg_tens=24, seg_ones=40. Press D12: roll_value=12, seg_tens=79, seg_ones=24.
- Bounce: toggle buttonD8 every DEBOUNCE_CYCLES/2 cycles for 10 toggles, then hold high. Exactly one roll occurs, and only after a full stable window.
- Simultaneous: buttonD10 and buttonD4 rise in the same cycle with switchTest=1 → roll_die=0, roll_value=4, single pulse.
- Normal mode, 1000 presses per die: every roll_value lies in 1..N, every face appears, and each result matches a reference model of (lfsr mod N)+1 taken in the event cycle.
